// File: rtl/spi_pkg.sv
// Shared definitions for the MMIO SPI master: engine states, register offsets
// and status-register bit positions.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } spi_state_t;

    localparam logic [11:0] DATA_OFS = 12'h500;
    localparam logic [11:0] STAT_OFS = 12'h501;

    localparam int unsigned STAT_DATA_AVAIL   = 0;
    localparam int unsigned STAT_BUFFER_EMPTY = 1;
    localparam int unsigned STAT_BUFFER_FULL  = 2;

    function automatic logic [7:0] status_byte(input logic data_avail,
                                               input logic buffer_empty,
                                               input logic buffer_full);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_DATA_AVAIL]   = data_avail;
        s[STAT_BUFFER_EMPTY] = buffer_empty;
        s[STAT_BUFFER_FULL]  = buffer_full;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with an extra pointer wrap bit; pushes to a full FIFO and
// pops from an empty one are ignored, judged on the pre-edge occupancy.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mmio_spi_master.sv
// MMIO SPI master, mode 0, MSB first: TX FIFO feeds a shift engine whose
// received bytes land in an RX FIFO.
module mmio_spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned TX_DEPTH = 4,
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_wr,
    input  logic       spi_rd,
    input  logic       spi_addr,
    input  logic [7:0] spi_din,
    input  logic       spi_ignore_response,
    output logic [7:0] spi_dout,
    output logic       spi_buffer_full,
    output logic       spi_buffer_empty,
    output logic       spi_data_avail,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = {{(DW-1){1'b0}}, 1'b1};

    spi_state_t state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          ign_q, ign_d;
    logic          sclk_q, sclk_d;
    logic          cs_n_q, cs_n_d;
    logic          load;

    logic                        tx_push, tx_pop, tx_full, tx_empty;
    logic                        rx_push, rx_pop, rx_full, rx_empty;
    logic [8:0]                  tx_head;
    logic [7:0]                  rx_head;
    logic [$clog2(TX_DEPTH):0]   tx_count;
    logic [$clog2(RX_DEPTH):0]   rx_count;

    assign tx_push = spi_wr && !spi_addr;
    assign rx_pop  = spi_rd && !spi_addr;

    sync_fifo #(.WIDTH(9), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   ({spi_ignore_response, spi_din}),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_sh_q),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        rx_sh_d = rx_sh_q;
        ign_d   = ign_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        load    = 1'b0;
        tx_pop  = 1'b0;
        rx_push = 1'b0;

        unique case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                load   = !tx_empty;
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = !sclk_q;
                    if (!sclk_q) begin
                        rx_sh_d = {rx_sh_q[6:0], miso};
                    end else begin
                        // Falling edge: next bit onto mosi; zeros shift in so
                        // mosi rests low once the byte is done.
                        shreg_d = {shreg_q[6:0], 1'b0};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = DONE;
                    end
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            DONE: begin
                rx_push = !ign_q && !rx_full;
                if (!tx_empty) begin
                    load = 1'b1;
                end else begin
                    cs_n_d  = 1'b1;
                    shreg_d = 8'h00;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            tx_pop  = 1'b1;
            shreg_d = tx_head[7:0];
            ign_d   = tx_head[8];
            cs_n_d  = 1'b0;
            div_d   = '0;
            bit_d   = 3'd0;
            sclk_d  = 1'b0;
            state_d = SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            rx_sh_q <= 8'h00;
            ign_q   <= 1'b0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            rx_sh_q <= rx_sh_d;
            ign_q   <= ign_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
        end
    end

    assign sclk             = sclk_q;
    assign mosi             = shreg_q[7];
    assign cs_n             = cs_n_q;
    assign spi_dout         = rx_empty ? 8'h00 : rx_head;
    assign spi_buffer_full  = tx_full;
    assign spi_buffer_empty = (tx_count == '0) && (state_q == IDLE);
    assign spi_data_avail   = (rx_count != '0);

endmodule

// File: tb/tb_mmio_spi_master.sv
// Bench for mmio_spi_master in loopback: a transaction-level model (byte queues
// plus a per-byte transfer time) predicts flags, cs_n, read data and wire bytes.
module tb_mmio_spi_master;

    localparam int unsigned CLK_DIV  = 2;
    localparam int unsigned TX_DEPTH = 4;
    localparam int unsigned RX_DEPTH = 4;
    localparam int          XFER     = 16 * CLK_DIV + 1;

    logic       clk, rst;
    logic       spi_wr, spi_rd, spi_addr, spi_ignore_response;
    logic [7:0] spi_din, spi_dout;
    logic       spi_buffer_full, spi_buffer_empty, spi_data_avail;
    logic       sclk, mosi, miso, cs_n;

    assign miso = mosi;

    mmio_spi_master #(
        .CLK_DIV  (CLK_DIV),
        .TX_DEPTH (TX_DEPTH),
        .RX_DEPTH (RX_DEPTH)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .spi_wr              (spi_wr),
        .spi_rd              (spi_rd),
        .spi_addr            (spi_addr),
        .spi_din             (spi_din),
        .spi_ignore_response (spi_ignore_response),
        .spi_dout            (spi_dout),
        .spi_buffer_full     (spi_buffer_full),
        .spi_buffer_empty    (spi_buffer_empty),
        .spi_data_avail      (spi_data_avail),
        .sclk                (sclk),
        .mosi                (mosi),
        .miso                (miso),
        .cs_n                (cs_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: queued bytes and cycles left in the byte on the wire
    logic [8:0] m_tx[$];
    logic [7:0] m_rx[$];
    logic [8:0] m_cur;
    int         m_timer;
    logic [7:0] exp_wire[$];
    logic [7:0] obs_wire[$];
    logic [7:0] bits_v;
    int         bits_n;
    int         n_rise;
    logic       sclk_prev;

    task automatic model_reset();
        m_tx.delete(); m_rx.delete(); exp_wire.delete(); obs_wire.delete();
        m_timer = 0; m_cur = 9'h0; bits_n = 0; bits_v = 8'h00; sclk_prev = 1'b0;
    endtask

    task automatic tick(input logic wr, input logic rd, input logic addr,
                        input logic [7:0] din, input logic ign);
        int txn, rxn;
        logic tx_pop, rx_push;
        logic [7:0] rx_byte;
        spi_wr = wr; spi_rd = rd; spi_addr = addr; spi_din = din; spi_ignore_response = ign;
        @(posedge clk);
        txn = m_tx.size(); rxn = m_rx.size();
        tx_pop = 1'b0; rx_push = 1'b0; rx_byte = m_cur[7:0];
        if (m_timer == 1) begin
            rx_push = !m_cur[8] && (rxn < RX_DEPTH);
            m_timer = 0;
        end else if (m_timer > 1) begin
            m_timer--;
        end
        if (m_timer == 0 && txn > 0) tx_pop = 1'b1;
        if (tx_pop) begin
            m_cur = m_tx.pop_front();
            exp_wire.push_back(m_cur[7:0]);
            m_timer = XFER;
        end
        if (wr && !addr && txn < TX_DEPTH) m_tx.push_back({ign, din});
        if (rd && !addr && rxn > 0) void'(m_rx.pop_front());
        if (rx_push) m_rx.push_back(rx_byte);
        @(negedge clk);
        spi_wr = 1'b0; spi_rd = 1'b0; spi_addr = 1'b0;
        if (sclk && !sclk_prev) begin
            n_rise++;
            bits_v = {bits_v[6:0], mosi};
            bits_n++;
            if (bits_n == 8) begin
                obs_wire.push_back(bits_v);
                bits_n = 0;
            end
        end
        sclk_prev = sclk;
    endtask

    task automatic run_idle();
        for (int c = 0; c < 8 * XFER && !(m_timer == 0 && m_tx.size() == 0); c++)
            tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain_rx();
        for (int c = 0; c < 2 * RX_DEPTH && m_rx.size() > 0; c++)
            tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (sclk !== 1'b0) $display("FAIL reset_sclk: got %b want 0", sclk); else n_pass++;
        n_checks++; if (mosi !== 1'b0) $display("FAIL reset_mosi: got %b want 0", mosi); else n_pass++;
        n_checks++; if (cs_n !== 1'b1) $display("FAIL reset_cs_n: got %b want 1", cs_n); else n_pass++;
        n_checks++; if (spi_dout !== 8'h00) $display("FAIL reset_dout: got %h want 00", spi_dout); else n_pass++;
        n_checks++; if (spi_buffer_full !== 1'b0) $display("FAIL reset_full: got %b want 0", spi_buffer_full); else n_pass++;
        n_checks++; if (spi_buffer_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", spi_buffer_empty); else n_pass++;
        n_checks++; if (spi_data_avail !== 1'b0) $display("FAIL reset_avail: got %b want 0", spi_data_avail); else n_pass++;
    endtask

    task automatic test_loopback();
        int low_cycles = 0;
        int avail_at = 0;
        exp_wire.delete(); obs_wire.delete();
        tick(1'b1, 1'b0, 1'b0, 8'hA5, 1'b0);
        for (int c = 1; c <= 40; c++) begin
            tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            if (!cs_n) low_cycles++;
            if (spi_data_avail && avail_at == 0) avail_at = c;
            n_checks++;
            if (cs_n !== (m_timer == 0)) $display("FAIL loop_cs_n c=%0d: got %b want %b", c, cs_n, m_timer == 0);
            else n_pass++;
        end
        n_checks++; if (low_cycles != 33) $display("FAIL loop_cs_low_len: got %0d want 33", low_cycles); else n_pass++;
        n_checks++; if (avail_at != 34) $display("FAIL loop_avail_at: got %0d want 34", avail_at); else n_pass++;
        n_checks++;
        if (obs_wire.size() != 1 || obs_wire[0] !== 8'hA5)
            $display("FAIL loop_mosi_bits: got %0d bytes first %h want A5", obs_wire.size(), obs_wire[0]);
        else n_pass++;
        n_checks++; if (spi_dout !== 8'hA5) $display("FAIL loop_dout: got %h want A5", spi_dout); else n_pass++;
        tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        n_checks++; if (spi_data_avail !== 1'b0) $display("FAIL loop_avail_after_rd: got %b want 0", spi_data_avail); else n_pass++;
    endtask

    task automatic test_ignore();
        int r0;
        exp_wire.delete(); obs_wire.delete();
        r0 = n_rise;
        tick(1'b1, 1'b0, 1'b0, 8'h13, 1'b1);
        for (int c = 0; c < 40; c++) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        n_checks++; if (n_rise - r0 != 8) $display("FAIL ign_sclk_pulses: got %0d want 8", n_rise - r0); else n_pass++;
        n_checks++;
        if (obs_wire.size() != 1 || obs_wire[0] !== 8'h13)
            $display("FAIL ign_mosi_bits: got %0d bytes first %h want 13", obs_wire.size(), obs_wire[0]);
        else n_pass++;
        n_checks++; if (spi_data_avail !== 1'b0) $display("FAIL ign_avail: got %b want 0", spi_data_avail); else n_pass++;
        n_checks++; if (spi_dout !== 8'h00) $display("FAIL ign_dout: got %h want 00", spi_dout); else n_pass++;
        tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        n_checks++; if (spi_dout !== 8'h00) $display("FAIL ign_dout_after_rd: got %h want 00", spi_dout); else n_pass++;
    endtask

    task automatic test_tx_overflow();
        logic [7:0] b[6];
        int rises = 0;
        int falls = 0;
        logic prev_cs = 1'b1;
        exp_wire.delete(); obs_wire.delete();
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0, 1'b0, b[i], 1'b0);
            if (cs_n && !prev_cs) rises++;
            if (!cs_n && prev_cs) falls++;
            prev_cs = cs_n;
            if (i == 4) begin
                n_checks++; if (spi_buffer_full !== 1'b1) $display("FAIL txov_full: got %b want 1", spi_buffer_full); else n_pass++;
            end
        end
        for (int c = 0; c < 6 * XFER && !(m_timer == 0 && m_tx.size() == 0); c++) begin
            tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            if (cs_n && !prev_cs) rises++;
            if (!cs_n && prev_cs) falls++;
            prev_cs = cs_n;
            n_checks++;
            if (cs_n !== (m_timer == 0)) $display("FAIL txov_cs_n c=%0d: got %b want %b", c, cs_n, m_timer == 0);
            else n_pass++;
        end
        n_checks++; if (rises != 1 || falls != 1) $display("FAIL txov_cs_continuous: got %0d rises %0d falls want 1 1", rises, falls); else n_pass++;
        n_checks++; if (obs_wire.size() != 5) $display("FAIL txov_count: got %0d want 5", obs_wire.size()); else n_pass++;
        for (int i = 0; i < 5 && i < obs_wire.size(); i++) begin
            n_checks++; if (obs_wire[i] !== b[i]) $display("FAIL txov_byte%0d: got %h want %h", i, obs_wire[i], b[i]); else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (spi_dout !== b[i]) $display("FAIL txov_rx%0d: got %h want %h", i, spi_dout, b[i]); else n_pass++;
            tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        end
        drain_rx();
    endtask

    task automatic test_rx_overflow();
        logic [7:0] b[5];
        for (int i = 0; i < 5; i++) begin
            b[i] = 8'($urandom);
            tick(1'b1, 1'b0, 1'b0, b[i], 1'b0);
            run_idle();
        end
        n_checks++; if (spi_data_avail !== 1'b1) $display("FAIL rxov_avail: got %b want 1", spi_data_avail); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (spi_dout !== b[i]) $display("FAIL rxov_byte%0d: got %h want %h", i, spi_dout, b[i]); else n_pass++;
            tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        end
        n_checks++; if (spi_data_avail !== 1'b0) $display("FAIL rxov_fifth_dropped: got %b want 0", spi_data_avail); else n_pass++;
        n_checks++; if (spi_dout !== 8'h00) $display("FAIL rxov_dout_empty: got %h want 00", spi_dout); else n_pass++;
    endtask

    task automatic test_status_read();
        tick(1'b1, 1'b0, 1'b0, 8'h5A, 1'b0);
        run_idle();
        tick(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        n_checks++; if (spi_data_avail !== 1'b1) $display("FAIL stat_no_pop: got %b want 1", spi_data_avail); else n_pass++;
        n_checks++; if (spi_dout !== 8'h5A) $display("FAIL stat_dout: got %h want 5A", spi_dout); else n_pass++;
        tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        n_checks++; if (spi_data_avail !== 1'b0) $display("FAIL stat_data_pop: got %b want 0", spi_data_avail); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] x, y;
        int r0, c;
        x = 8'($urandom);
        y = 8'($urandom);
        r0 = n_rise;
        tick(1'b1, 1'b0, 1'b0, x, 1'b0);
        tick(1'b1, 1'b0, 1'b0, ~x, 1'b0);
        for (c = 0; c < 200 && n_rise - r0 < 3; c++) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        n_checks++; if (n_rise - r0 < 3) $display("FAIL rstmid_wait_sclk: got %0d rises want 3", n_rise - r0); else n_pass++;
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (cs_n !== 1'b1) $display("FAIL rstmid_cs_n: got %b want 1", cs_n); else n_pass++;
        n_checks++; if (sclk !== 1'b0) $display("FAIL rstmid_sclk: got %b want 0", sclk); else n_pass++;
        n_checks++; if (spi_buffer_empty !== 1'b1) $display("FAIL rstmid_tx_empty: got %b want 1", spi_buffer_empty); else n_pass++;
        n_checks++; if (spi_data_avail !== 1'b0) $display("FAIL rstmid_rx_empty: got %b want 0", spi_data_avail); else n_pass++;
        tick(1'b1, 1'b0, 1'b0, y, 1'b0);
        run_idle();
        n_checks++; if (spi_dout !== y) $display("FAIL rstmid_new_xfer: got %h want %h", spi_dout, y); else n_pass++;
        n_checks++;
        if (obs_wire.size() != 1 || obs_wire[0] !== y)
            $display("FAIL rstmid_wire: got %0d bytes first %h want %h", obs_wire.size(), obs_wire[0], y);
        else n_pass++;
        drain_rx();
    endtask

    task automatic test_random();
        logic wr, rd, addr, ign;
        logic [7:0] din, exp_dout;
        exp_wire.delete(); obs_wire.delete();
        for (int c = 0; c < 3000; c++) begin
            wr   = ($urandom_range(5) == 0);
            rd   = ($urandom_range(19) == 0);
            addr = ($urandom_range(7) == 0);
            ign  = ($urandom_range(3) == 0);
            din  = 8'($urandom);
            exp_dout = (m_rx.size() > 0) ? m_rx[0] : 8'h00;
            n_checks++; if (cs_n !== (m_timer == 0)) $display("FAIL rnd_cs_n c=%0d: got %b want %b", c, cs_n, m_timer == 0); else n_pass++;
            n_checks++; if (spi_buffer_full !== (m_tx.size() == TX_DEPTH)) $display("FAIL rnd_full c=%0d: got %b want %b", c, spi_buffer_full, m_tx.size() == TX_DEPTH); else n_pass++;
            n_checks++; if (spi_buffer_empty !== (m_tx.size() == 0 && m_timer == 0)) $display("FAIL rnd_empty c=%0d: got %b want %b", c, spi_buffer_empty, m_tx.size() == 0 && m_timer == 0); else n_pass++;
            n_checks++; if (spi_data_avail !== (m_rx.size() > 0)) $display("FAIL rnd_avail c=%0d: got %b want %b", c, spi_data_avail, m_rx.size() > 0); else n_pass++;
            n_checks++; if (spi_dout !== exp_dout) $display("FAIL rnd_dout c=%0d: got %h want %h", c, spi_dout, exp_dout); else n_pass++;
            tick(wr, rd, addr, din, ign);
        end
        run_idle();
        n_checks++; if (obs_wire.size() != exp_wire.size()) $display("FAIL rnd_wire_count: got %0d want %0d", obs_wire.size(), exp_wire.size()); else n_pass++;
        for (int i = 0; i < obs_wire.size() && i < exp_wire.size(); i++) begin
            n_checks++; if (obs_wire[i] !== exp_wire[i]) $display("FAIL rnd_wire%0d: got %h want %h", i, obs_wire[i], exp_wire[i]); else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1;
        spi_wr = 1'b0; spi_rd = 1'b0; spi_addr = 1'b0; spi_din = 8'h00; spi_ignore_response = 1'b0;
        n_rise = 0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_loopback();
        test_ignore();
        test_tx_overflow();
        test_rx_overflow();
        test_status_read();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
